// File: rtl/cl_mcl_pkg.sv
// ---------------------------------------------------------------------------
// cl_mcl_pkg
//   Shared definitions for the manycore link (MCL) host bridge:
//   - host FIFO register offsets (AXI-Lite, 12-bit decoded window)
//   - ISR bit positions for transmit-complete and receive-complete
//   - manycore response packet layout (128 bits)
//   - responder FSM state encoding and small helpers
// ---------------------------------------------------------------------------
package cl_mcl_pkg;

    // Host FIFO register map offsets
    localparam logic [11:0] FIFO_ISR_OFFSET_p      = 12'h000;
    localparam logic [11:0] FIFO_TDFV_OFFSET_p     = 12'h00C;
    localparam logic [11:0] FIFO_TDR_OFFSET_p      = 12'h010;
    localparam logic [11:0] FIFO_RDFO_OFFSET_p     = 12'h01C;
    localparam logic [11:0] FIFO_RDR_OFFSET_p      = 12'h020;
    localparam logic [11:0] FIFO_RLR_OFFSET_p      = 12'h024;
    localparam logic [11:0] MCL_RCV_VACANCY_OFFSET_p = 12'h200;

    // ISR bit positions
    localparam int FIFO_ISR_TC_BIT_p = 27;  // transmit complete
    localparam int FIFO_ISR_RC_BIT_p = 26;  // receive complete (data waiting)

    // One response packet is four 32-bit words = 16 bytes
    localparam int MCL_WORDS_PER_PKT_p = 4;
    localparam logic [31:0] MCL_PKT_BYTES_p = 32'd16;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY_p   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR_p = 2'b10;

    // Manycore response packet; word 0 of the host view is bits [31:0]
    typedef struct packed {
        logic [31:0] padding;
        logic [7:0]  pkt_type;
        logic [31:0] data;
        logic [31:0] load_id;
        logic [7:0]  y_cord;
        logic [15:0] x_cord;
    } bsg_mcl_response_s;

    // Read-channel FSM: one outstanding read at a time
    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_RESP = 1'b1
    } rsp_state_e;

    // Words still readable: whole packets minus words already taken from the head
    function automatic logic [31:0] rdfo_words(input logic [31:0] pkt_count,
                                               input logic [1:0]  word_idx);
        return (pkt_count << 2) - {30'd0, word_idx};
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// ---------------------------------------------------------------------------
// bsg_fifo_1r1w_small
//   Small synchronous FIFO with valid/ready input and valid/yumi output.
//   The head entry is presented combinationally on data_o whenever v_o is
//   high; yumi_i pops it on the next clock edge. A push while full is ignored.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   v_i, ready_o        push handshake (ready_o = not full)
//   data_i              push data, width_p bits
//   v_o, data_o         head valid and head data
//   yumi_i              pop the head (only legal when v_o)
// ---------------------------------------------------------------------------
module bsg_fifo_1r1w_small #(
    parameter int width_p = 128,
    parameter int els_p   = 64,
    localparam int ptr_width_lp   = $clog2(els_p),
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q,  count_d;
    logic                      push, pop;

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign push = v_i & ready_o;
    assign pop  = yumi_i & v_o;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // els_p is a power of two, so pointers wrap by natural overflow
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together at the edge regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count
    // define which entries are meaningful, and a reset-free array maps to RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_mcl_rsp_to_axil.sv
// ---------------------------------------------------------------------------
// bsg_mcl_rsp_to_axil
//   AXI-Lite read-only responder delivering manycore responses to the host.
//   Buffers 128-bit response packets and serves them as 32-bit words through
//   the receive registers of the host FIFO map: ISR, RDFO, RDR, RLR and the
//   response vacancy register.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   mc_rsp_v_i/mc_rsp_i/mc_rsp_ready_o   manycore response input (valid/ready)
//   araddr_i/arvalid_i/arready_o   AXI-Lite read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i    AXI-Lite read data channel
//   rcv_vacancy_o                  free packet slots, for credit logic
// ---------------------------------------------------------------------------
module bsg_mcl_rsp_to_axil
    import cl_mcl_pkg::*;
#(
    parameter int fifo_els_p        = 64,
    parameter int axil_addr_width_p = 32,
    localparam int count_width_lp   = $clog2(fifo_els_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         mc_rsp_v_i,
    input  logic [127:0]                 mc_rsp_i,
    output logic                         mc_rsp_ready_o,

    input  logic [axil_addr_width_p-1:0] araddr_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [31:0]                  rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,

    output logic [count_width_lp-1:0]    rcv_vacancy_o
);

    rsp_state_e                state_q, state_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [1:0]                word_idx_q, word_idx_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic                      fifo_ready, fifo_v;
    logic [127:0]              fifo_data;
    logic [3:0][31:0]          head_words;
    logic                      enq, pop;
    logic [11:0]               reg_addr;
    logic [count_width_lp-1:0] vacancy;

    bsg_fifo_1r1w_small #(
        .width_p (128),
        .els_p   (fifo_els_p)
    ) rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq),
        .ready_o (fifo_ready),
        .data_i  (mc_rsp_i),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (pop)
    );

    // Ready reflects only the registered occupancy; a pop in the same cycle
    // does not open a slot until the following cycle.
    assign mc_rsp_ready_o = fifo_ready & ~reset_i;
    assign enq            = mc_rsp_v_i & mc_rsp_ready_o;

    assign head_words     = fifo_data;
    assign reg_addr       = araddr_i[11:0];
    assign vacancy        = count_width_lp'(fifo_els_p) - count_q;

    assign arready_o      = (state_q == RSP_IDLE) & ~reset_i;
    assign rvalid_o       = (state_q == RSP_RESP);
    assign rdata_o        = rdata_q;
    assign rresp_o        = rresp_q;
    assign rcv_vacancy_o  = vacancy;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        pop        = 1'b0;

        case (state_q)
            RSP_IDLE: begin
                if (arvalid_i && arready_o) begin
                    state_d = RSP_RESP;
                    rdata_d = '0;
                    rresp_d = AXI_RESP_OKAY_p;
                    // Data is taken from the state seen in this cycle, before
                    // this cycle's enqueue or pop lands.
                    case (reg_addr)
                        FIFO_ISR_OFFSET_p:
                            rdata_d[FIFO_ISR_RC_BIT_p] = fifo_v;
                        FIFO_RDFO_OFFSET_p:
                            rdata_d = rdfo_words(32'(count_q), word_idx_q);
                        FIFO_RLR_OFFSET_p:
                            rdata_d = fifo_v ? MCL_PKT_BYTES_p : 32'd0;
                        FIFO_RDR_OFFSET_p: begin
                            if (fifo_v) begin
                                rdata_d    = head_words[word_idx_q];
                                word_idx_d = word_idx_q + 2'd1;
                                pop        = (word_idx_q == 2'd3);
                            end else begin
                                rresp_d = AXI_RESP_SLVERR_p;
                            end
                        end
                        MCL_RCV_VACANCY_OFFSET_p:
                            rdata_d = 32'(vacancy);
                        default: ;
                    endcase
                end
            end
            RSP_RESP: begin
                if (rready_i) state_d = RSP_IDLE;
            end
            default: state_d = RSP_IDLE;
        endcase

        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= RSP_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_bsg_mcl_rsp_to_axil.sv
module tb_bsg_mcl_rsp_to_axil;

    localparam int ELS = 64;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         mc_rsp_v_i = 1'b0;
    logic [127:0] mc_rsp_i = '0;
    logic         mc_rsp_ready_o;
    logic [31:0]  araddr_i = '0;
    logic         arvalid_i = 1'b0;
    logic         arready_o;
    logic [31:0]  rdata_o;
    logic [1:0]   rresp_o;
    logic         rvalid_o;
    logic         rready_i = 1'b0;
    logic [6:0]   rcv_vacancy_o;

    int total = 0;
    int bad   = 0;

    bsg_mcl_rsp_to_axil #(.fifo_els_p(ELS), .axil_addr_width_p(32)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .mc_rsp_v_i     (mc_rsp_v_i),
        .mc_rsp_i       (mc_rsp_i),
        .mc_rsp_ready_o (mc_rsp_ready_o),
        .araddr_i       (araddr_i),
        .arvalid_i      (arvalid_i),
        .arready_o      (arready_o),
        .rdata_o        (rdata_o),
        .rresp_o        (rresp_o),
        .rvalid_o       (rvalid_o),
        .rready_i       (rready_i),
        .rcv_vacancy_o  (rcv_vacancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fill_pkt(input int i);
        return {32'(i * 4 + 3), 32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)} | {4{32'hA000_0000}};
    endfunction

    function automatic logic [31:0] pkt_word(input logic [127:0] p, input int k);
        logic [3:0][31:0] w;
        w = p;
        return w[k];
    endfunction

    // Presents an address until accepted; returns #1 after the accept edge.
    task automatic ar_accept(input logic [11:0] addr);
        bit done = 0;
        araddr_i  = {20'd0, addr};
        arvalid_i = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            if (arready_o) done = 1;
            @(posedge clk_i); #1;
        end
        arvalid_i = 1'b0;
        if (!done) check("ar_timeout", 32'(arready_o), 32'd1);
    endtask

    task automatic r_take(output logic [31:0] data, output logic [1:0] resp);
        check("rvalid_after_ar", 32'(rvalid_o), 32'd1);
        data = rdata_o;
        resp = rresp_o;
        rready_i = 1'b1;
        @(posedge clk_i); #1;
        rready_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        ar_accept(addr);
        r_take(d, r);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic enqueue(input logic [127:0] p);
        bit done = 0;
        mc_rsp_v_i = 1'b1;
        mc_rsp_i   = p;
        for (int n = 0; n < 20 && !done; n++) begin
            if (mc_rsp_ready_o) done = 1;
            @(posedge clk_i); #1;
        end
        mc_rsp_v_i = 1'b0;
        if (!done) check("enq_timeout", 32'(mc_rsp_ready_o), 32'd1);
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin : main
        logic [127:0] p0, pa, pb;
        logic [31:0]  d0;
        logic [1:0]   r0;

        // Reset state
        #2 reset_i = 1'b1;
        #1;
        check("rst_arready", 32'(arready_o), 32'd0);
        check("rst_rvalid",  32'(rvalid_o), 32'd0);
        check("rst_rdata",   rdata_o, 32'd0);
        check("rst_rresp",   32'(rresp_o), 32'd0);
        check("rst_vacancy", 32'(rcv_vacancy_o), 32'd64);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        check("rst_mc_ready", 32'(mc_rsp_ready_o), 32'd1);
        check("rst_arready_rel", 32'(arready_o), 32'd1);
        @(posedge clk_i); #1;

        // Empty-buffer register reads
        read_chk("rdfo_empty", 12'h01C, 32'd0, 2'b00);
        read_chk("rlr_empty",  12'h024, 32'd0, 2'b00);
        read_chk("vac_empty",  12'h200, 32'd64, 2'b00);
        read_chk("isr_empty",  12'h000, 32'd0, 2'b00);
        read_chk("unmapped",   12'h004, 32'd0, 2'b00);

        // Single packet, read out word by word
        p0 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        enqueue(p0);
        read_chk("isr_rc",  12'h000, 32'h0400_0000, 2'b00);
        read_chk("rdfo_4",  12'h01C, 32'd4, 2'b00);
        read_chk("rlr_16",  12'h024, 32'd16, 2'b00);
        read_chk("rdr_w0",  12'h020, 32'h1111_1111, 2'b00);
        read_chk("rdfo_3",  12'h01C, 32'd3, 2'b00);
        read_chk("rdr_w1",  12'h020, 32'h2222_2222, 2'b00);
        read_chk("rdr_w2",  12'h020, 32'h3333_3333, 2'b00);
        read_chk("rdr_w3",  12'h020, 32'h4444_4444, 2'b00);
        read_chk("rdfo_0",  12'h01C, 32'd0, 2'b00);
        read_chk("vac_64",  12'h200, 32'd64, 2'b00);

        // RDR on empty buffer
        read_chk("rdr_empty", 12'h020, 32'd0, 2'b10);
        check("rdr_empty_vac", 32'(rcv_vacancy_o), 32'd64);
        read_chk("rdfo_after_err", 12'h01C, 32'd0, 2'b00);

        // Fill to capacity
        for (int i = 0; i < ELS; i++) enqueue(fill_pkt(i));
        check("full_ready", 32'(mc_rsp_ready_o), 32'd0);
        check("full_vac_port", 32'(rcv_vacancy_o), 32'd0);
        read_chk("full_vac_reg", 12'h200, 32'd0, 2'b00);
        read_chk("full_rdfo", 12'h01C, 32'd256, 2'b00);
        // 65th packet held off
        mc_rsp_v_i = 1'b1;
        mc_rsp_i   = fill_pkt(64);
        repeat (2) @(posedge clk_i);
        #1;
        check("held_ready", 32'(mc_rsp_ready_o), 32'd0);
        check("held_vac", 32'(rcv_vacancy_o), 32'd0);
        read_chk("full_w0", 12'h020, pkt_word(fill_pkt(0), 0), 2'b00);
        read_chk("full_w1", 12'h020, pkt_word(fill_pkt(0), 1), 2'b00);
        read_chk("full_w2", 12'h020, pkt_word(fill_pkt(0), 2), 2'b00);
        ar_accept(12'h020);
        check("pop_ready_next", 32'(mc_rsp_ready_o), 32'd1);
        check("pop_vac_next", 32'(rcv_vacancy_o), 32'd1);
        r_take(d0, r0);
        check("full_w3", d0, pkt_word(fill_pkt(0), 3));
        mc_rsp_v_i = 1'b0;
        check("refill_vac", 32'(rcv_vacancy_o), 32'd0);
        read_chk("refill_head", 12'h020, pkt_word(fill_pkt(1), 0), 2'b00);

        // Fresh start for stall and simultaneous enqueue/pop
        pulse_reset();
        check("flush_vac", 32'(rcv_vacancy_o), 32'd64);
        pa = fill_pkt(100);
        pb = fill_pkt(101);
        enqueue(pa);
        enqueue(pb);
        ar_accept(12'h020);
        for (int n = 0; n < 5; n++) begin
            check("stall_rdata",   rdata_o, pkt_word(pa, 0));
            check("stall_arready", 32'(arready_o), 32'd0);
            check("stall_rvalid",  32'(rvalid_o), 32'd1);
            @(posedge clk_i); #1;
        end
        r_take(d0, r0);
        check("stall_final", d0, pkt_word(pa, 0));
        read_chk("a_w1", 12'h020, pkt_word(pa, 1), 2'b00);
        read_chk("a_w2", 12'h020, pkt_word(pa, 2), 2'b00);
        mc_rsp_v_i = 1'b1;
        mc_rsp_i   = fill_pkt(102);
        ar_accept(12'h020);
        mc_rsp_v_i = 1'b0;
        r_take(d0, r0);
        check("a_w3", d0, pkt_word(pa, 3));
        check("simul_vac", 32'(rcv_vacancy_o), 32'd62);
        read_chk("simul_rdfo", 12'h01C, 32'd8, 2'b00);
        read_chk("b_w0", 12'h020, pkt_word(pb, 0), 2'b00);
        read_chk("b_w1", 12'h020, pkt_word(pb, 1), 2'b00);

        // Reset in the middle of a transaction with a partial packet
        ar_accept(12'h020);
        check("pre_rst_rvalid", 32'(rvalid_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
        check("mid_rst_arready", 32'(arready_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("post_rst_ready", 32'(mc_rsp_ready_o), 32'd1);
        read_chk("post_rst_rdfo", 12'h01C, 32'd0, 2'b00);
        read_chk("post_rst_vac",  12'h200, 32'd64, 2'b00);
        read_chk("post_rst_isr",  12'h000, 32'd0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
